ce_gen_frac: RTL
================

Name: ce_gen_frac

Overview:
- Multi-channel fractional clock-enable generator; a single clk_sys domain drives all channels.
- Replaces fixed integer pixel/CPU enable counters in the top level. One channel serves the pixel enable, e.g. divide-by-6 or divide-by-12 from 48 MHz.
- Another channel serves the CPU enable at 1/2/4/8/10 MHz; 10 MHz is not an integer divisor of 48 MHz.
- Rate per channel is f_clk*inc/mod. Rate changes take effect glitch-free on a period boundary, with hold (freeze) and global resync.

Parameters:
- CHANNELS, 2, number of independent enable outputs.
- ACC_W, 8, width of the inc, mod and accumulator fields.
- DEF_INC, 1, active inc for every channel after reset.
- DEF_MOD, 48, active mod for every channel after reset.

Ports:
- clk_sys  in  1  system clock, e.g. 48 MHz.
- n_reset  in  1  synchronous, active-low reset.
- en  in  CHANNELS  per-channel enable; 0 = channel idle.
- hold  in  CHANNELS  per-channel freeze, e.g. during ioctl_download.
- sync  in  1  one-cycle strobe realigning all channels.
- cfg_valid  in  CHANNELS  per-channel new-rate request.
- cfg_inc  in  CHANNELS*ACC_W  requested inc; channel c occupies bits [c*ACC_W +: ACC_W].
- cfg_mod  in  CHANNELS*ACC_W  requested mod, same packing as cfg_inc.
- cfg_ready  out  CHANNELS  shadow register of the channel is empty.
- ce  out  CHANNELS  registered one-cycle enable pulses.
- cfg_active  out  CHANNELS  1 while the channel's shadow is pending.

Behaviour:
- Reset (n_reset=0 at a clk_sys edge), per channel:
  - acc=0, active inc=DEF_INC, active mod=DEF_MOD.
  - Shadow empty, ce=0, cfg_ready=1, cfg_active=0.
  - Reset mid-pending discards the shadow.
- Per-channel state:
  - active {inc, mod}, acc[ACC_W-1:0].
  - One-entry shadow {inc, mod, full}.
- Accumulation:
  - sum = acc + inc, computed ACC_W+1 bits wide; no overflow is possible.
  - Each cycle with en=1, hold=0, sync=0:
    - sum >= mod: acc <= sum - mod and ce <= 1.
    - Otherwise: acc <= sum[ACC_W-1:0] and ce <= 0.
- Latency:
  - ce is high in the cycle after the edge on which the wrap is computed.
  - With inc=1, mod=6 from acc=0: ce is first high after the 6th edge, then exactly every 6 cycles.
- Degenerate configurations:
  - inc=0 or mod=0: ce stays 0 and acc is held.
  - inc >= mod (mod != 0): ce=1 every cycle and acc is held at 0.
- Config handshake:
  - A transfer occurs when cfg_valid & cfg_ready; the shadow loads and full=1.
  - cfg_ready = ~full, combinational from the register.
  - cfg_valid while full is ignored; the requester must hold it.
- Config apply:
  - Enabled, not held: the shadow is applied on the same edge that sets ce=1. The post-wrap acc is kept, but forced to 0 if it is >= the new mod. The new rate governs from the next cycle; full clears.
  - en=0: the shadow is applied on the next edge and acc is cleared.
  - hold=1: apply is deferred.
  - A new transfer is accepted no earlier than the cycle after full clears.
- Hold:
  - acc and the active config are frozen; ce=0.
  - On release, resume from the held acc; no extra or lost pulse.
- en=0: ce=0 and acc=0.
- Sync:
  - All channels: acc <= 0 and ce <= 0.
  - Any full shadow is applied immediately.
  - sync has priority over hold and wrap.
  - After sync, all channels with equal config pulse in the same cycle.
- Simultaneous events, priority order:
  1. n_reset
  2. sync
  3. en=0
  4. hold
  5. wrap/apply
  6. accumulate
- Outputs: all registered except cfg_ready, which derives directly from the full flip-flop.

Decomposition:
- Package ce_gen_pkg:
  - typedef cfg_t {logic [ACC_W-1:0] inc, mod;}, where ACC_W is a package parameter.
  - Rate constants for 48 MHz:
    - PIX_HI {1,6}, PIX_LO {1,12}
    - CPU_1M {1,48}, CPU_2M {1,24}, CPU_4M {1,12}, CPU_8M {1,6}, CPU_10M {5,24}
- Sub-module ce_gen_chan: one channel's accumulator, shadow and priority logic.
- Top ce_gen_frac is a generate loop over ce_gen_chan, fanning out sync.

Test Plan:
- Reset release, default {1,48}, en=1 -> first ce after 48 edges, then period 48; cfg_ready=1.
- Config {5,24} -> exactly 5 ce pulses per 24 cycles, spacing only 4 or 5 cycles, zero long-term drift over 2400 cycles (500 pulses).
- Config {1,6} active, request {1,12} mid-period -> change applies on the next ce; that period is 6, subsequent periods are 12; cfg_ready low from acceptance until that ce.
- hold=1 for 20 cycles mid-period with {1,6} -> no ce during hold; the next ce comes exactly (6 - elapsed) cycles after release.
- Two channels {1,6} and {1,12} plus sync -> both ce low for the sync cycle; ce0 after 6 cycles and ce1 after 12 cycles, coincident every 12.
- Config {0,6} -> ce never asserts. Config {7,6} -> ce=1 every cycle. n_reset pulsed with the shadow full -> shadow discarded, {1,48} restored.

Source files
------------

// File: rtl/ce_gen_pkg.sv
// Shared field width, per-channel rate record and the standard rates for a 48 MHz clk_sys.
package ce_gen_pkg;

  localparam int ACC_W = 8;

  typedef struct packed {
    logic [ACC_W-1:0] inc;
    logic [ACC_W-1:0] mod;
  } cfg_t;

  localparam cfg_t PIX_HI  = '{inc: 8'd1, mod: 8'd6};
  localparam cfg_t PIX_LO  = '{inc: 8'd1, mod: 8'd12};
  localparam cfg_t CPU_1M  = '{inc: 8'd1, mod: 8'd48};
  localparam cfg_t CPU_2M  = '{inc: 8'd1, mod: 8'd24};
  localparam cfg_t CPU_4M  = '{inc: 8'd1, mod: 8'd12};
  localparam cfg_t CPU_8M  = '{inc: 8'd1, mod: 8'd6};
  localparam cfg_t CPU_10M = '{inc: 8'd5, mod: 8'd24};

endpackage

// File: rtl/ce_gen_chan.sv
// One fractional enable channel: phase accumulator, one-entry rate shadow and
// the sync > en > hold > wrap > accumulate priority chain.
module ce_gen_chan
  import ce_gen_pkg::*;
#(
  parameter int ACC_W   = 8,
  parameter int DEF_INC = 1,
  parameter int DEF_MOD = 48
) (
  input  logic             clk_sys,
  input  logic             n_reset,
  input  logic             en,
  input  logic             hold,
  input  logic             sync,
  input  logic             cfg_valid,
  input  logic [ACC_W-1:0] cfg_inc,
  input  logic [ACC_W-1:0] cfg_mod,
  output logic             cfg_ready,
  output logic             ce,
  output logic             cfg_active
);

  logic [ACC_W-1:0] acc_q, inc_q, mod_q, sh_inc_q, sh_mod_q;
  logic             full_q, ce_q;

  logic [ACC_W:0]   sum, diff;
  logic [ACC_W-1:0] acc_wrap;
  logic             degen, wrap, accept;

  assign sum    = {1'b0, acc_q} + {1'b0, inc_q};
  assign diff   = sum - {1'b0, mod_q};
  assign degen  = (inc_q == '0) || (mod_q == '0);
  assign wrap   = !degen && (sum >= {1'b0, mod_q});
  assign accept = cfg_valid && !full_q;

  // inc >= mod saturates to a pulse every cycle; pin acc so it cannot drift.
  assign acc_wrap = (inc_q >= mod_q) ? '0 : diff[ACC_W-1:0];

  always_ff @(posedge clk_sys) begin
    if (!n_reset) begin
      acc_q    <= '0;
      inc_q    <= ACC_W'(DEF_INC);
      mod_q    <= ACC_W'(DEF_MOD);
      sh_inc_q <= '0;
      sh_mod_q <= '0;
      full_q   <= 1'b0;
      ce_q     <= 1'b0;
    end else begin
      if (accept) begin
        sh_inc_q <= cfg_inc;
        sh_mod_q <= cfg_mod;
        full_q   <= 1'b1;
      end
      if (sync || !en) begin
        acc_q <= '0;
        ce_q  <= 1'b0;
        if (full_q) begin
          inc_q  <= sh_inc_q;
          mod_q  <= sh_mod_q;
          full_q <= 1'b0;
        end
      end else if (hold) begin
        ce_q <= 1'b0;
      end else if (wrap) begin
        ce_q <= 1'b1;
        if (full_q) begin
          inc_q  <= sh_inc_q;
          mod_q  <= sh_mod_q;
          full_q <= 1'b0;
          acc_q  <= (acc_wrap >= sh_mod_q) ? '0 : acc_wrap;
        end else begin
          acc_q <= acc_wrap;
        end
      end else begin
        ce_q <= 1'b0;
        if (!degen) acc_q <= sum[ACC_W-1:0];
      end
    end
  end

  assign cfg_ready  = ~full_q;
  assign cfg_active = full_q;
  assign ce         = ce_q;

endmodule

// File: rtl/ce_gen_frac.sv
// Multi-channel fractional clock-enable generator; each channel pulses at f_clk*inc/mod.
module ce_gen_frac
  import ce_gen_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int ACC_W    = 8,
  parameter int DEF_INC  = 1,
  parameter int DEF_MOD  = 48
) (
  input  logic                      clk_sys,
  input  logic                      n_reset,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS-1:0]       hold,
  input  logic                      sync,
  input  logic [CHANNELS-1:0]       cfg_valid,
  input  logic [CHANNELS*ACC_W-1:0] cfg_inc,
  input  logic [CHANNELS*ACC_W-1:0] cfg_mod,
  output logic [CHANNELS-1:0]       cfg_ready,
  output logic [CHANNELS-1:0]       ce,
  output logic [CHANNELS-1:0]       cfg_active
);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    ce_gen_chan #(
      .ACC_W  (ACC_W),
      .DEF_INC(DEF_INC),
      .DEF_MOD(DEF_MOD)
    ) u_chan (
      .clk_sys   (clk_sys),
      .n_reset   (n_reset),
      .en        (en[g]),
      .hold      (hold[g]),
      .sync      (sync),
      .cfg_valid (cfg_valid[g]),
      .cfg_inc   (cfg_inc[g*ACC_W +: ACC_W]),
      .cfg_mod   (cfg_mod[g*ACC_W +: ACC_W]),
      .cfg_ready (cfg_ready[g]),
      .ce        (ce[g]),
      .cfg_active(cfg_active[g])
    );
  end

endmodule
